// File: rtl/vram_fetch_if.sv
// vram_fetch_if -- bundle of every non-clock signal of vram_fetch.
//   Renderer side : fetch_nt/fetch_attr/fetch_chr, pattern_idx, inc_cx, inc_y,
//                   return00 in; fine_x, data_o, attr_o out.
//   CPU side      : reg_wr, reg_rd, reg_addr, reg_wdata in; reg_rdata, reg_rvalid out.
//   VRAM side     : vram_addr, vram_rd, vram_wr, vram_wdata out; vram_rdata in.
// Modport slave is the fetch unit itself; master is whatever drives it.
interface vram_fetch_if;
  logic        fetch_nt;
  logic        fetch_attr;
  logic        fetch_chr;
  logic [12:0] pattern_idx;
  logic        inc_cx;
  logic        inc_y;
  logic        return00;
  logic        reg_wr;
  logic        reg_rd;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        reg_rvalid;
  logic [2:0]  fine_x;
  logic [7:0]  data_o;
  logic [1:0]  attr_o;
  logic [13:0] vram_addr;
  logic        vram_rd;
  logic        vram_wr;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;

  modport slave (
    input  fetch_nt, fetch_attr, fetch_chr, pattern_idx, inc_cx, inc_y, return00,
    input  reg_wr, reg_rd, reg_addr, reg_wdata, vram_rdata,
    output reg_rdata, reg_rvalid, fine_x, data_o, attr_o,
    output vram_addr, vram_rd, vram_wr, vram_wdata
  );

  modport master (
    output fetch_nt, fetch_attr, fetch_chr, pattern_idx, inc_cx, inc_y, return00,
    output reg_wr, reg_rd, reg_addr, reg_wdata, vram_rdata,
    input  reg_rdata, reg_rvalid, fine_x, data_o, attr_o,
    input  vram_addr, vram_rd, vram_wr, vram_wdata
  );
endinterface

// File: rtl/vram_fetch.sv
// vram_fetch -- PPU-style VRAM address generator and fetch arbiter.
//   Holds the scroll registers v/t/x/w, generates nametable, attribute and
//   pattern fetch addresses for the renderer, and slots CPU PPUDATA (reg 7)
//   accesses into cycles the renderer leaves free.
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : vram_fetch_if.slave (renderer strobes, CPU register port, VRAM port)
// Configuration macro:
//   PPUDATA_RDBUF_EN : when defined, PPUDATA reads return the previous read's
//                      byte through a one-deep buffer; otherwise the byte just
//                      read is returned.
module vram_fetch (
  input logic         clk,
  input logic         rst_n,
  vram_fetch_if.slave bus
);

  logic [14:0] v_reg, v_next;
  logic [14:0] t_reg, t_next;
  logic [2:0]  x_reg, x_next;
  logic        w_reg, w_next;
  logic        inc32_reg, inc32_next;
  logic [1:0]  shift_reg;
  logic        pend_valid_reg;
  logic        pend_rd_reg;
  logic [7:0]  pend_data_reg;
  logic        rd_inflight_reg;
  logic [7:0]  rdata_reg;
`ifdef PPUDATA_RDBUF_EN
  logic [7:0]  rdbuf_reg;
`endif

  logic        fetch_any;
  logic        reg7_acc;
  logic        slot_valid;
  logic        slot_rd;
  logic [7:0]  slot_data;
  logic        cpu_issue;
  logic [13:0] attr_addr;
  logic [13:0] nt_addr;
  logic [14:0] v_cx;
  logic [14:0] v_incy;
  logic [7:0]  rd_result;
  logic [1:0]  quad_bits [4];

  assign fetch_any = bus.fetch_nt | bus.fetch_attr | bus.fetch_chr;
  assign reg7_acc  = (bus.reg_wr | bus.reg_rd) && (bus.reg_addr == 3'd7);

  // The slot seen this cycle is either the held access or a fresh one, so an
  // idle cycle issues a new reg 7 access without waiting for it to be latched.
  assign slot_valid = pend_valid_reg | reg7_acc;
  assign slot_rd    = pend_valid_reg ? pend_rd_reg   : ~bus.reg_wr;
  assign slot_data  = pend_valid_reg ? pend_data_reg : bus.reg_wdata;
  assign cpu_issue  = slot_valid & ~fetch_any;

  assign attr_addr = 14'h23C0 | {2'b00, v_reg[11:10], 10'd0}
                              | {8'd0, v_reg[9:7], 3'd0}
                              | {11'd0, v_reg[4:2]};
  assign nt_addr   = {2'b10, v_reg[11:0]};

  // VRAM port; held at zero while in reset.
  always_comb begin
    bus.vram_addr  = 14'd0;
    bus.vram_rd    = 1'b0;
    bus.vram_wr    = 1'b0;
    bus.vram_wdata = 8'd0;
    if (rst_n) begin
      if (bus.fetch_chr)
        bus.vram_addr = {1'b0, bus.pattern_idx};
      else if (bus.fetch_attr)
        bus.vram_addr = attr_addr;
      else if (bus.fetch_nt)
        bus.vram_addr = nt_addr;
      else
        bus.vram_addr = v_reg[13:0];
      bus.vram_rd = fetch_any | (cpu_issue & slot_rd);
      bus.vram_wr = cpu_issue & ~slot_rd;
      if (cpu_issue && !slot_rd)
        bus.vram_wdata = slot_data;
    end
  end

  assign bus.data_o = bus.vram_rdata;
  assign bus.fine_x = x_reg;

  // Attribute byte holds four 2-bit palette fields, one per 16x16 quadrant.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_quad
      assign quad_bits[gi] = bus.vram_rdata[2*gi+1:2*gi];
    end
  endgenerate
  assign bus.attr_o = quad_bits[shift_reg];

`ifdef PPUDATA_RDBUF_EN
  assign rd_result = rdbuf_reg;
`else
  assign rd_result = bus.vram_rdata;
`endif

  // The read result is presented in the completion cycle itself and then held.
  assign bus.reg_rvalid = rd_inflight_reg;
  assign bus.reg_rdata  = rd_inflight_reg ? rd_result : rdata_reg;

  // Coarse X increment wraps into the horizontal nametable bit.
  assign v_cx = (v_reg[4:0] == 5'd31) ? {v_reg[14:11], ~v_reg[10], v_reg[9:5], 5'd0}
                                      : {v_reg[14:5], v_reg[4:0] + 5'd1};

  // End-of-line Y increment with horizontal bits reloaded from t.
  // Coarse Y 29 is the last visible row; 30/31 are attribute rows that wrap
  // without switching nametables.
  always_comb begin
    v_incy = v_reg;
    if (v_reg[14:12] != 3'd7) begin
      v_incy[14:12] = v_reg[14:12] + 3'd1;
    end else begin
      v_incy[14:12] = 3'd0;
      if (v_reg[9:5] == 5'd29) begin
        v_incy[9:5] = 5'd0;
        v_incy[11]  = ~v_reg[11];
      end else if (v_reg[9:5] == 5'd31) begin
        v_incy[9:5] = 5'd0;
      end else begin
        v_incy[9:5] = v_reg[9:5] + 5'd1;
      end
    end
    v_incy[10]  = t_reg[10];
    v_incy[4:0] = t_reg[4:0];
  end

  // Sources of v are applied lowest precedence first so later ones win.
  always_comb begin
    v_next     = v_reg;
    t_next     = t_reg;
    x_next     = x_reg;
    w_next     = w_reg;
    inc32_next = inc32_reg;
    if (cpu_issue)
      v_next = v_reg + (inc32_reg ? 15'd32 : 15'd1);
    if (bus.inc_cx)
      v_next = v_cx;
    if (bus.inc_y)
      v_next = v_incy;
    if (bus.return00)
      v_next = t_reg;
    if (bus.reg_wr) begin
      case (bus.reg_addr)
        3'd0: begin
          t_next[11:10] = bus.reg_wdata[1:0];
          inc32_next    = bus.reg_wdata[2];
        end
        3'd5: begin
          if (!w_reg) begin
            t_next[4:0] = bus.reg_wdata[7:3];
            x_next      = bus.reg_wdata[2:0];
            w_next      = 1'b1;
          end else begin
            t_next[14:12] = bus.reg_wdata[2:0];
            t_next[9:5]   = bus.reg_wdata[7:3];
            w_next        = 1'b0;
          end
        end
        3'd6: begin
          if (!w_reg) begin
            t_next[13:8] = bus.reg_wdata[5:0];
            t_next[14]   = 1'b0;
            w_next       = 1'b1;
          end else begin
            t_next[7:0] = bus.reg_wdata;
            v_next      = {t_reg[14:8], bus.reg_wdata};
            w_next      = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (bus.reg_rd && bus.reg_addr == 3'd2) begin
      w_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg           <= 15'd0;
      t_reg           <= 15'd0;
      x_reg           <= 3'd0;
      w_reg           <= 1'b0;
      inc32_reg       <= 1'b0;
      shift_reg       <= 2'd0;
      pend_valid_reg  <= 1'b0;
      pend_rd_reg     <= 1'b0;
      pend_data_reg   <= 8'd0;
      rd_inflight_reg <= 1'b0;
      rdata_reg       <= 8'd0;
`ifdef PPUDATA_RDBUF_EN
      rdbuf_reg       <= 8'd0;
`endif
    end else begin
      v_reg     <= v_next;
      t_reg     <= t_next;
      x_reg     <= x_next;
      w_reg     <= w_next;
      inc32_reg <= inc32_next;
      if (bus.fetch_attr)
        shift_reg <= {v_reg[6], v_reg[1]};
      // A slot not issued (renderer busy) is held; a reg 7 access arriving
      // while one is already held is dropped.
      pend_valid_reg <= slot_valid & ~cpu_issue;
      if (reg7_acc && !pend_valid_reg) begin
        pend_rd_reg   <= ~bus.reg_wr;
        pend_data_reg <= bus.reg_wdata;
      end
      rd_inflight_reg <= cpu_issue & slot_rd;
      if (rd_inflight_reg) begin
        rdata_reg <= rd_result;
`ifdef PPUDATA_RDBUF_EN
        rdbuf_reg <= bus.vram_rdata;
`endif
      end
    end
  end

endmodule
